// File: rtl/cpu_board_pkg.sv
// Shared constants for the cpu_32_board: source-select encodings, seven-segment
// glyph table (active-low {g,f,e,d,c,b,a}) and display idle levels.
package cpu_board_pkg;

  typedef enum logic [1:0] {
    SEL_PC   = 2'd0,
    SEL_INST = 2'd1,
    SEL_ALUC = 2'd2,
    SEL_DATA = 2'd3
  } sel_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Glyphs for 0..F; entry [n] is the pattern for nibble value n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/cpu_hex_display_hex7seg_decode.sv
// Combinational 4-bit to active-low seven-segment decoder.
module hex7seg_decode
  import cpu_board_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/cpu_hex_display.sv
// Snapshots one CPU debug word and scans it as 8 hex digits on a common-anode display.
// Optional leading-zero blanking: define CPU_HEX_DISPLAY_LZB_EN.
module cpu_hex_display
  import cpu_board_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc,
  input  logic [31:0]           inst,
  input  logic [31:0]           aluc,
  input  logic [31:0]           data,
  input  logic [1:0]            sel,
  input  logic                  step,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned IDX_W    = $clog2(NUM_DIGITS);
  localparam int unsigned DP_DIGIT = 4;

  logic [31:0]           r_snap;
  logic [1:0]            r_sel_q;
  logic [15:0]           r_div;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;

  logic [31:0] w_mux;
  logic        w_load;
  logic        w_adv;
  logic [3:0]  w_nib;
  logic [6:0]  w_glyph;
  logic        w_lz_blank;

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    w_mux = pc;
    unique case (sel_e'(sel))
      SEL_PC:   w_mux = pc;
      SEL_INST: w_mux = inst;
      SEL_ALUC: w_mux = aluc;
      SEL_DATA: w_mux = data;
    endcase
  end

  assign w_load = step || (sel != r_sel_q);
  assign w_adv  = (r_div == 16'(SCAN_DIV - 1));
  assign w_nib  = r_snap[{r_idx, 2'b00} +: 4];

`ifdef CPU_HEX_DISPLAY_LZB_EN
  // Blank when this nibble and every nibble above it are zero; digit 0 always shows.
  assign w_lz_blank = (r_idx != '0) && ((r_snap >> {r_idx, 2'b00}) == 32'd0);
`else
  assign w_lz_blank = 1'b0;
`endif

  hex7seg_decode u_decode (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap  <= '0;
      r_sel_q <= '0;
      r_div   <= '0;
      r_idx   <= '0;
      r_an    <= AN_OFF;
      r_seg   <= SEG_BLANK;
      r_dp    <= 1'b1;
    end else begin
      r_sel_q <= sel;
      if (w_load) r_snap <= w_mux;

      if (w_adv) begin
        r_div <= '0;
        r_idx <= r_idx + 1'b1;
      end else begin
        r_div <= r_div + 16'd1;
      end

      // One all-off cycle at each digit change keeps the old segments off the new anode.
      r_an  <= w_adv ? AN_OFF : ~(NUM_DIGITS'(1) << r_idx);
      r_dp  <= w_adv ? 1'b1 : (r_idx != IDX_W'(DP_DIGIT));
      r_seg <= w_lz_blank ? SEG_BLANK : w_glyph;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: doc/cpu_hex_display.md
Name: cpu_hex_display

Overview:
- Downstream board-level consumer of the 32-bit CPU core's debug outputs (pc, inst, aluc, data).
- Selects one word by switch, snapshots it on a CPU-step strobe, and time-multiplexes it as 8 hex digits onto an active-low common-anode seven-segment display.
- Sits between the CPU core and the board I/O pins in the cpu_32_board top level.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit is driven. Legal range is 2..65535.
- NUM_DIGITS, 8: number of display digits, one nibble each. Fixed at 8 for a 32-bit word.

Ports:
- clk  in  1  board clock.
- rst  in  1  asynchronous, active-low reset. 0 = reset.
- pc  in  32  CPU program counter.
- inst  in  32  CPU current instruction.
- aluc  in  32  CPU ALU result.
- data  in  32  CPU memory/write data.
- sel  in  2  source select: 0 = pc, 1 = inst, 2 = aluc, 3 = data.
- step  in  1  one-cycle pulse, synchronous to clk, marking a CPU clock edge. Triggers a snapshot.
- an  out  8  digit enables, active-low. an[0] is the rightmost digit (bits 3:0).
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset values (rst=0, asynchronous): an=8'hFF, seg=7'h7F, dp=1, snapshot=0, sel_q=0, div counter=0, digit index=0.
- Snapshot register:
  - Loads the mux of pc/inst/aluc/data by sel when step=1, or when sel differs from the registered sel_q.
  - The new value is visible in the cycle after the load.
  - sel_q updates every cycle.
  - If step and a sel change occur in the same cycle, a single load uses the new sel.
- Divider:
  - Counts 0..SCAN_DIV-1 and wraps.
  - At terminal count, the digit index increments modulo 8 (7 wraps to 0).
- Blanking:
  - In the cycle the index advances, an is forced to 8'hFF for exactly one cycle (anti-ghosting).
  - In every other cycle, an = ~(1 << index).
- Segment data:
  - seg is the registered hex decode of snapshot[4*index+3 : 4*index].
  - Output latency is one cycle from an index or snapshot change.
- Hex decode, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- dp is low only on digit 4, marking the 16-bit halfword boundary. Otherwise dp is 1.
- A snapshot change mid-scan takes effect on the current digit at the next cycle; the scan is not restarted.
- rst asserted mid-scan returns all outputs to their reset values immediately.
- After rst deasserts, the first digit is driven at the first clock.

Optional Feature:
- Macro: CPU_HEX_DISPLAY_LZB_EN.
- When defined, leading-zero blanking is enabled:
  - Any digit above the highest nonzero nibble drives seg=7'h7F. Its an still strobes normally.
  - Digit 0 is always shown, so a value of 0 displays "0".
  - dp is unaffected.
- When not defined, all 8 digits always show their hex value.

Decomposition:
- Shared package cpu_board_pkg holds:
  - Select encodings SEL_PC, SEL_INST, SEL_ALUC, SEL_DATA.
  - The 16-entry segment constant table.
  - SEG_BLANK=7'h7F and AN_OFF=8'hFF.
- One sub-module, hex7seg_decode: combinational 4-bit to 7-segment decoder, instantiated once on the muxed nibble.

Test Plan (SCAN_DIV=4 in the bench):
- Reset: hold rst=0 with arbitrary inputs -> an=FF, seg=7F, dp=1. Release rst -> an walks FE, FD, FB, ... with one FF cycle between digits; each digit lasts 4 cycles including the blank.
- Snapshot: pc=32'h0040_001C, sel=0, pulse step -> digits 0..7 show C,1,0,0,0,4,0,0 (seg 46,79,40,40,40,19,40,40); dp low only while an=EF.
- Select change: sel 0->2 with aluc=32'hDEAD_BEEF and no step -> next cycle the snapshot is DEADBEEF; digit 0 shows seg=0E. Then change aluc with no step -> display unchanged.
- Simultaneous: step=1 in the same cycle as sel 2->3 with data=32'h0000_0055 -> snapshot=00000055.
- Wrap and reset mid-scan: after digit 7, the index returns to 0 (an=FE after one FF cycle). Asserting rst while an=F7 gives an=FF in the same cycle without waiting for a clock edge.
- LZB build (CPU_HEX_DISPLAY_LZB_EN): value 32'h0000_0100 -> digits 3..7 show 7F and digits 0..2 show 40,40,79. Value 0 -> only digit 0 shows 40.
